pc_fetch_unit: RTL and testbench

Parametrised program-counter unit for the RISC-V core. It holds the fetch address, advances it under a valid/ready handshake with instruction memory, and accepts execute-stage redirects and traps. A small return-address stack (RAS) predicts call/return targets. It sits between the trap/branch logic and the instruction-fetch port.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_fetch_unit_if.sv | 30 +++
 rtl/pc_ras.sv | 73 +++++++
 rtl/pc_fetch_unit.sv | 92 +++++++++
 tb/tb_pc_fetch_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter / fetch-address unit.
// Imported by the interface, the RAS and the top.
package pc_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam int          INSN_BYTES       = 4;
  localparam int          RAS_DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_MISALIGN,
    SEL_REDIRECT,
    SEL_RAS,
    SEL_SEQ,
    SEL_HOLD
  } pc_sel_e;

  // Only the two low bits matter for a 4-byte instruction grid.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-port and control bundle for pc_fetch_unit. The master side is the
// PC unit itself; the slave side is the fetch port / trap-branch logic.
interface pc_fetch_unit_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            fetch_ready;
  logic            is_call;
  logic            is_ret;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            misaligned_err;
  logic [CW-1:0]   ras_count;

  modport master (
    input  fetch_ready, is_call, is_ret, redirect_valid, redirect_pc, trap_valid,
    output pc, pc_valid, misaligned_err, ras_count
  );

  modport slave (
    output fetch_ready, is_call, is_ret, redirect_valid, redirect_pc, trap_valid,
    input  pc, pc_valid, misaligned_err, ras_count
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push silently overwrites the
// oldest entry because the write pointer simply wraps.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic            push_pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] mem_reg [DEPTH];
  logic [PW-1:0]   ptr_reg, ptr_next, ptr_dec;
  logic [CW-1:0]   count_reg, count_next;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic            empty, full;

  assign ptr_dec = ptr_reg - PW'(1);
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));

  always_comb begin
    ptr_next   = ptr_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_idx     = ptr_reg;
    if (flush) begin
      ptr_next   = '0;
      count_next = '0;
    end else if (push_pop && !empty) begin
      // Call-and-return in one instruction: replace the top in place.
      wr_en  = 1'b1;
      wr_idx = ptr_dec;
    end else if (push || push_pop) begin
      wr_en      = 1'b1;
      wr_idx     = ptr_reg;
      ptr_next   = ptr_reg + PW'(1);
      count_next = full ? count_reg : count_reg + CW'(1);
    end else if (pop && !empty) begin
      ptr_next   = ptr_dec;
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_idx] <= din;
    end
  end

  assign top   = mem_reg[ptr_dec];
  assign count = count_reg;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with fetch handshake, redirect/trap priority mux and a
// small return-address stack for call/return prediction.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
  parameter int              RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_unit_if.master fif
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [XLEN-1:0] pc_reg, pc_next, seq_pc, ras_top;
  logic            pc_valid_reg, mis_err_reg;
  logic            fire, ras_en, ras_push, ras_pop, ras_push_pop, ras_flush;
  logic [CW-1:0]   ras_count;
  pc_sel_e         sel;

  assign fire   = pc_valid_reg & fif.fetch_ready;
  assign seq_pc = pc_reg + XLEN'(INSN_BYTES);

  always_comb begin
    sel = SEL_HOLD;
    if (fif.trap_valid) begin
      sel = SEL_TRAP;
    end else if (fif.redirect_valid && is_misaligned(fif.redirect_pc[1:0])) begin
      sel = SEL_MISALIGN;
    end else if (fif.redirect_valid) begin
      sel = SEL_REDIRECT;
    end else if (fire && fif.is_ret && ras_count != '0) begin
      sel = SEL_RAS;
    end else if (fire) begin
      sel = SEL_SEQ;
    end
  end

  always_comb begin
    pc_next = pc_reg;
    case (sel)
      SEL_TRAP, SEL_MISALIGN: pc_next = TRAP_VECTOR;
      SEL_REDIRECT:           pc_next = fif.redirect_pc;
      SEL_RAS:                pc_next = ras_top;
      SEL_SEQ:                pc_next = seq_pc;
      default:                pc_next = pc_reg;
    endcase
  end

  // Predecode hints only count on a clean fire; redirects and traps win.
  assign ras_en       = fire & ~fif.trap_valid & ~fif.redirect_valid;
  assign ras_push     = ras_en & fif.is_call & ~fif.is_ret;
  assign ras_pop      = ras_en & fif.is_ret & ~fif.is_call;
  assign ras_push_pop = ras_en & fif.is_call & fif.is_ret;
  assign ras_flush    = (sel == SEL_TRAP) || (sel == SEL_MISALIGN);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_VECTOR;
      pc_valid_reg <= 1'b0;
      mis_err_reg  <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      pc_valid_reg <= 1'b1;
      mis_err_reg  <= (sel == SEL_MISALIGN);
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .flush    (ras_flush),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_pop (ras_push_pop),
    .din      (seq_pc),
    .top      (ras_top),
    .count    (ras_count)
  );

  assign fif.pc             = pc_reg;
  assign fif.pc_valid       = pc_valid_reg;
  assign fif.misaligned_err = mis_err_reg;
  assign fif.ras_count      = ras_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit against a queue-based
// reference model of the next-pc and return-stack rules.
module tb_pc_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) fif ();

  pc_fetch_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif.master)
  );

  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_mis;
  logic [31:0] m_ras[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit fr, input bit call, input bit ret,
                            input bit rv, input logic [31:0] rpc, input bit tv);
    logic [31:0] seq;
    bit          fire;
    if (rst) begin
      m_pc = RV; m_valid = 0; m_mis = 0; m_ras.delete();
      return;
    end
    fire  = m_valid && fr;
    seq   = m_pc + 32'd4;
    m_mis = 0;
    if (tv) begin
      m_pc = TV; m_ras.delete();
    end else if (rv && rpc[1:0] != 2'b00) begin
      m_pc = TV; m_mis = 1; m_ras.delete();
    end else if (rv) begin
      m_pc = rpc;
    end else if (fire) begin
      if (call && ret) begin
        if (m_ras.size() > 0) begin
          m_pc = m_ras[m_ras.size()-1];
          m_ras[m_ras.size()-1] = seq;
        end else begin
          m_pc = seq;
          m_ras.push_back(seq);
        end
      end else if (ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else                  m_pc = seq;
      end else if (call) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(seq);
        m_pc = seq;
      end else begin
        m_pc = seq;
      end
    end
    m_valid = 1;
  endtask

  task automatic step(input bit rst, input bit fr, input bit call, input bit ret,
                      input bit rv, input logic [31:0] rpc, input bit tv);
    @(negedge clk);
    reset              = rst;
    fif.fetch_ready    = fr;
    fif.is_call        = call;
    fif.is_ret         = ret;
    fif.redirect_valid = rv;
    fif.redirect_pc    = rpc;
    fif.trap_valid     = tv;
    @(posedge clk);
    model_step(rst, fr, call, ret, rv, rpc, tv);
    #1;
    chk("pc",        64'(fif.pc),             64'(m_pc));
    chk("pc_valid",  64'(fif.pc_valid),       64'(m_valid));
    chk("mis_err",   64'(fif.misaligned_err), 64'(m_mis));
    chk("ras_count", 64'(fif.ras_count),      64'(m_ras.size()));
    $display("cyc rst=%0b fr=%0b c=%0b r=%0b rv=%0b rpc=%08h tv=%0b -> pc=%08h v=%0b me=%0b cnt=%0d",
             rst, fr, call, ret, rv, rpc, tv, fif.pc, fif.pc_valid, fif.misaligned_err, fif.ras_count);
  endtask

  task automatic fire_i(input bit call, input bit ret);
    step(0, 1, call, ret, 0, 32'h0, 0);
  endtask

  task automatic redir(input logic [31:0] a);
    step(0, 0, 0, 0, 1, a, 0);
  endtask

  initial begin
    logic [31:0] ret_exp [4];
    reset = 1'b1;
    fif.fetch_ready = 0; fif.is_call = 0; fif.is_ret = 0;
    fif.redirect_valid = 0; fif.redirect_pc = '0; fif.trap_valid = 0;
    m_pc = RV; m_valid = 0; m_mis = 0;

    // reset and sequential fetch
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("rst_valid", 64'(fif.pc_valid), 64'd0);
    chk("rst_pc", 64'(fif.pc), 64'h0);
    fire_i(0, 0); chk("seq0", 64'(fif.pc), 64'h0);
    chk("valid_up", 64'(fif.pc_valid), 64'd1);
    fire_i(0, 0); chk("seq4", 64'(fif.pc), 64'h4);
    fire_i(0, 0); chk("seq8", 64'(fif.pc), 64'h8);
    fire_i(0, 0); chk("seqC", 64'(fif.pc), 64'hC);

    // stall then redirect while stalled
    redir(32'h8);
    step(0, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 0);
    chk("stall", 64'(fif.pc), 64'h8);
    redir(32'h40); chk("redir40", 64'(fif.pc), 64'h40);

    // single call / return
    redir(32'h10);
    fire_i(1, 0); chk("call_pc", 64'(fif.pc), 64'h14);
    chk("call_cnt", 64'(fif.ras_count), 64'd1);
    redir(32'h200);
    fire_i(0, 0); fire_i(0, 0);
    chk("at208", 64'(fif.pc), 64'h208);
    fire_i(0, 1); chk("ret_pc", 64'(fif.pc), 64'h14);
    chk("ret_cnt", 64'(fif.ras_count), 64'd0);

    // overflow then drain
    for (int i = 0; i < 5; i++) begin
      redir(32'(i * 32'h20));
      fire_i(1, 0);
    end
    chk("ovf_cnt", 64'(fif.ras_count), 64'd4);
    ret_exp = '{32'h84, 32'h64, 32'h44, 32'h24};
    for (int i = 0; i < 4; i++) begin
      fire_i(0, 1);
      chk("drain", 64'(fif.pc), 64'(ret_exp[i]));
    end
    fire_i(0, 1); chk("underflow", 64'(fif.pc), 64'h28);
    chk("uf_cnt", 64'(fif.ras_count), 64'd0);

    // call+ret on empty and non-empty stack
    fire_i(1, 1); chk("cr_empty_pc", 64'(fif.pc), 64'h2C);
    chk("cr_empty_cnt", 64'(fif.ras_count), 64'd1);
    redir(32'h300);
    fire_i(1, 1); chk("cr_top_pc", 64'(fif.pc), 64'h2C);
    chk("cr_top_cnt", 64'(fif.ras_count), 64'd1);
    fire_i(0, 1); chk("cr_ret", 64'(fif.pc), 64'h304);

    // misaligned redirect, trap priority
    fire_i(1, 0);
    redir(32'h102);
    chk("mis_pc", 64'(fif.pc), 64'h100);
    chk("mis_hi", 64'(fif.misaligned_err), 64'd1);
    chk("mis_flush", 64'(fif.ras_count), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("mis_lo", 64'(fif.misaligned_err), 64'd0);
    step(0, 1, 1, 0, 1, 32'h102, 1);
    chk("trap_pc", 64'(fif.pc), 64'h100);
    chk("trap_nomis", 64'(fif.misaligned_err), 64'd0);

    // wrap and mid-stall reset
    redir(32'hFFFF_FFFC);
    fire_i(0, 0); chk("wrap", 64'(fif.pc), 64'h0);
    fire_i(1, 0); fire_i(1, 0); fire_i(1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_cnt", 64'(fif.ras_count), 64'd3);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_pc", 64'(fif.pc), 64'h0);
    chk("mid_rst_cnt", 64'(fif.ras_count), 64'd0);
    chk("mid_rst_v", 64'(fif.pc_valid), 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0;
      step($urandom_range(0, 199) == 0, ($urandom % 4) != 0,
           ($urandom % 4) == 0, ($urandom % 4) == 0,
           ($urandom % 12) == 0, rpc, ($urandom % 40) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
